// File: rtl/count_monitor_display.sv
// count_monitor_display
//   Observation stage for a 4-bit free-running counter. Every cycle it samples
//   the counter, flags illegal steps (sticky), counts F->0 wrap-arounds in a
//   2-digit BCD tally, and scans a 4-digit active-low 7-segment display:
//     digit0 = current count (hex), digit1 = error indicator ('E' or blank),
//     digit2 = tally ones, digit3 = tally tens.
//
// Parameters
//   SCAN_DIV  clock cycles each digit is held before the scan advances (>= 2)
//   SATURATE  1: tally holds at 99; 0: tally rolls 99 -> 00
//
// Ports
//   clk         clock, all state on rising edge
//   rstn        asynchronous active-low reset
//   count_in    counter value, sampled every cycle
//   clr         synchronous clear of tally, error flag and history
//   wrap_pulse  one-cycle pulse per detected F->0 wrap
//   wraps_bcd   wrap tally, [7:4] tens, [3:0] ones
//   step_err    sticky illegal-step flag
//   an_n        digit enables, active-low
//   seg_n       segments, active-low, bit0 = a ... bit6 = g
module count_monitor_display #(
  parameter int unsigned SCAN_DIV = 4,
  parameter bit          SATURATE = 1'b1
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [3:0] count_in,
  input  logic       clr,
  output logic       wrap_pulse,
  output logic [7:0] wraps_bcd,
  output logic       step_err,
  output logic [3:0] an_n,
  output logic [6:0] seg_n
);

  localparam int unsigned      DW       = $clog2(SCAN_DIV);
  localparam logic [DW-1:0]    DIV_LAST = DW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    DIG_COUNT = 2'd0,
    DIG_ERR   = 2'd1,
    DIG_ONES  = 2'd2,
    DIG_TENS  = 2'd3
  } digit_e;

  logic [3:0]    prev_q, prev_d;
  logic          prev_valid_q, prev_valid_d;
  logic          wrap_q, wrap_d;
  logic [7:0]    wraps_q, wraps_d;
  logic          err_q, err_d;
  logic [DW-1:0] div_q, div_d;
  digit_e        dig_q, dig_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;

  logic [3:0]    prev_inc;
  logic          wrap_det;
  logic          step_ok;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
    endcase
    return s;
  endfunction

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] != 4'd9) begin
      r = {v[7:4], v[3:0] + 4'd1};
    end else if (v[7:4] != 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = SATURATE ? 8'h99 : 8'h00;
    end
    return r;
  endfunction

  assign prev_inc = prev_q + 4'd1;
  assign wrap_det = prev_valid_q && (prev_q == 4'hF) && (count_in == 4'h0);
  // 0 is always accepted: the upstream counter may be reset/resynchronised.
  assign step_ok  = (count_in == prev_q) || (count_in == prev_inc) || (count_in == 4'h0);

  always_comb begin
    prev_d       = count_in;
    prev_valid_d = 1'b1;
    wrap_d       = 1'b0;
    wraps_d      = wraps_q;
    err_d        = err_q;
    div_d        = div_q;
    dig_d        = dig_q;
    an_d         = 4'hF;
    seg_d        = 7'h7F;

    // clr overrides any wrap or error detected in the same cycle.
    if (clr) begin
      prev_valid_d = 1'b0;
      wraps_d      = '0;
      err_d        = 1'b0;
    end else begin
      wrap_d = wrap_det;
      if (wrap_det) wraps_d = bcd_inc(wraps_q);
      if (prev_valid_q && !step_ok) err_d = 1'b1;
    end

    // Scan state is independent of clr.
    if (div_q == DIV_LAST) begin
      div_d = '0;
      dig_d = digit_e'(dig_q + 2'd1);
    end else begin
      div_d = div_q + DW'(1);
    end

    // Display registers take the current digit index and the source
    // registers as they stand this cycle, so they lag the index by one cycle.
    an_d = ~(4'b0001 << dig_q);
    case (dig_q)
      DIG_COUNT: seg_d = hex7(prev_q);
      DIG_ERR:   seg_d = err_q ? 7'h06 : 7'h7F;
      DIG_ONES:  seg_d = hex7(wraps_q[3:0]);
      default:   seg_d = hex7(wraps_q[7:4]);
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      wrap_q       <= 1'b0;
      wraps_q      <= '0;
      err_q        <= 1'b0;
      div_q        <= '0;
      dig_q        <= DIG_COUNT;
      an_q         <= '1;
      seg_q        <= '1;
    end else begin
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
      wrap_q       <= wrap_d;
      wraps_q      <= wraps_d;
      err_q        <= err_d;
      div_q        <= div_d;
      dig_q        <= dig_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
    end
  end

  assign wrap_pulse = wrap_q;
  assign wraps_bcd  = wraps_q;
  assign step_err   = err_q;
  assign an_n       = an_q;
  assign seg_n      = seg_q;

endmodule
